// File: rtl/mux_n1_reg.sv
// N-channel registered multiplexer with manual or round-robin auto-scan select and a valid/ready output stage.
// Optional macro MUX_PARITY_EN adds oparity, the XOR-reduce of the loaded word.
module mux_n1_reg #(
    parameter int WIDTH = 4,
    parameter int NCH   = 4,
    parameter int DWELL = 2,
    localparam int SELW = $clog2(NCH)
) (
    input  logic                 iclk,
    input  logic                 irst_n,
    input  logic [NCH*WIDTH-1:0] idata,
    input  logic [SELW-1:0]      isel,
    input  logic                 imode,
    input  logic                 ivalid,
    input  logic                 iready,
    output logic [WIDTH-1:0]     odata,
    output logic [SELW-1:0]      och,
    output logic                 ovalid
`ifdef MUX_PARITY_EN
    ,
    output logic                 oparity
`endif
);

    localparam int DCW   = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int NSLOT = 1 << SELW;

    typedef enum logic {MANUAL, SCAN} state_t;

    state_t                      state, state_nx;
    logic                        mode_q;
    logic [SELW-1:0]             scan_ch, scan_ch_nx, cur_sel;
    logic [DCW-1:0]              dwell_cnt, dwell_nx;
    logic [NSLOT-1:0][WIDTH-1:0] slot;
    logic                        load;

    // Select codes past NCH-1 map to zero-filled slots so out-of-range picks load 0.
    for (genvar k = 0; k < NSLOT; k++) begin : g_slot
        if (k < NCH) begin : g_live
            assign slot[k] = idata[k*WIDTH +: WIDTH];
        end else begin : g_pad
            assign slot[k] = '0;
        end
    end

    assign load = ivalid && (!ovalid || iready);

    always_comb begin
        state_nx   = state;
        scan_ch_nx = scan_ch;
        dwell_nx   = dwell_cnt;
        cur_sel    = isel;
        case (state)
            MANUAL: begin
                cur_sel = isel;
                if (imode && !mode_q) begin
                    state_nx   = SCAN;
                    scan_ch_nx = '0;
                    dwell_nx   = '0;
                end
            end
            SCAN: begin
                cur_sel = scan_ch;
                if (!imode && mode_q) begin
                    state_nx   = MANUAL;
                    scan_ch_nx = '0;
                    dwell_nx   = '0;
                end else if (load) begin
                    // Only accepted samples count toward dwell, so stalls never skip a channel.
                    if (dwell_cnt == DCW'(DWELL - 1)) begin
                        dwell_nx   = '0;
                        scan_ch_nx = (scan_ch == SELW'(NCH - 1)) ? '0 : scan_ch + 1'b1;
                    end else begin
                        dwell_nx = dwell_cnt + 1'b1;
                    end
                end
            end
            default: state_nx = MANUAL;
        endcase
    end

    always_ff @(posedge iclk) begin
        if (!irst_n) begin
            state     <= MANUAL;
            mode_q    <= 1'b0;
            scan_ch   <= '0;
            dwell_cnt <= '0;
            odata     <= '0;
            och       <= '0;
            ovalid    <= 1'b0;
`ifdef MUX_PARITY_EN
            oparity   <= 1'b0;
`endif
        end else begin
            state     <= state_nx;
            mode_q    <= imode;
            scan_ch   <= scan_ch_nx;
            dwell_cnt <= dwell_nx;
            if (load) begin
                odata   <= slot[cur_sel];
                och     <= cur_sel;
                ovalid  <= 1'b1;
`ifdef MUX_PARITY_EN
                oparity <= ^slot[cur_sel];
`endif
            end else if (iready) begin
                ovalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_n1_reg.sv
// Scoreboard bench for mux_n1_reg: directed stimulus pushes expected words, a negedge monitor pops on transfer.
module tb_mux_n1_reg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] idata;
    logic [1:0]  isel;
    logic        imode, ivalid, iready;
    logic [3:0]  odata;
    logic [1:0]  och;
    logic        ovalid;
`ifdef MUX_PARITY_EN
    logic        oparity;
`endif

    typedef struct {
        logic [1:0] ch;
        logic [3:0] data;
        logic       par;
    } exp_t;

    exp_t q[$];
    int   pass_cnt = 0;
    int   tot_cnt  = 0;
    logic chk_zero = 1'b0;

    mux_n1_reg #(.WIDTH(4), .NCH(4), .DWELL(2)) dut (
        .iclk   (clk),
        .irst_n (rst_n),
        .idata  (idata),
        .isel   (isel),
        .imode  (imode),
        .ivalid (ivalid),
        .iready (iready),
        .odata  (odata),
        .och    (och),
        .ovalid (ovalid)
`ifdef MUX_PARITY_EN
        ,
        .oparity(oparity)
`endif
    );

    always #5 clk = ~clk;

    // Monitor: outputs are stable at negedge; ovalid && iready here means a transfer at the next edge.
    always @(negedge clk) begin
        if (chk_zero) begin
            tot_cnt++;
            if (ovalid !== 1'b0 || odata !== 4'h0 || och !== 2'd0)
                $display("FAIL reset_zero: got ovalid=%b odata=%h och=%0d, want 0/0/0", ovalid, odata, och);
            else
                pass_cnt++;
        end
        if (ovalid === 1'b1) begin
            tot_cnt++;
            if (q.size() == 0) begin
                $display("FAIL spurious_out: got odata=%h och=%0d with nothing expected", odata, och);
            end else begin
                if (och !== q[0].ch || odata !== q[0].data)
                    $display("FAIL out_word: got och=%0d odata=%h, want och=%0d odata=%h",
                             och, odata, q[0].ch, q[0].data);
                else
                    pass_cnt++;
`ifdef MUX_PARITY_EN
                tot_cnt++;
                if (oparity !== q[0].par)
                    $display("FAIL parity: got %b, want %b", oparity, q[0].par);
                else
                    pass_cnt++;
`endif
                if (iready === 1'b1) void'(q.pop_front());
            end
        end
    end

    task automatic step(input logic r, input logic v, input logic rdy, input logic m,
                        input logic [1:0] s, input logic z,
                        input logic ld, input logic [1:0] ch, input logic [3:0] d);
        exp_t e;
        rst_n    = r;
        ivalid   = v;
        iready   = rdy;
        imode    = m;
        isel     = s;
        chk_zero = z;
        if (ld) begin
            e.ch   = ch;
            e.data = d;
            e.par  = ^d;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        idata  = {4'h4, 4'h3, 4'h2, 4'h1};
        rst_n  = 1'b0;
        ivalid = 1'b1;
        iready = 1'b1;
        imode  = 1'b0;
        isel   = 2'd0;
        @(posedge clk);
        #1;

        // Reset held with traffic present
        for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0, 1, 0, 0, 0);

        // Manual sweep, first load in the release cycle
        step(1, 1, 1, 0, 0, 1, 1, 0, 4'h1);
        step(1, 1, 1, 0, 1, 0, 1, 1, 4'h2);
        step(1, 1, 1, 0, 2, 0, 1, 2, 4'h3);
        step(1, 1, 1, 0, 3, 0, 1, 3, 4'h4);

        // Backpressure
        step(1, 1, 1, 0, 1, 0, 1, 1, 4'h2);
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 3, 0, 0, 0, 0);
        step(1, 1, 1, 0, 3, 0, 1, 3, 4'h4);

        // Enter scan with a bubble in the transition cycle, then 10 loads with wrap
        step(1, 0, 1, 1, 3, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            logic [1:0] c;
            c = 2'((i / 2) % 4);
            step(1, 1, 1, 1, 3, 0, 1, c, 4'(c) + 4'h1);
        end

        // Scan stall then bubble: no channel skipped
        step(1, 1, 1, 1, 3, 0, 1, 1, 4'h2);
        for (int i = 0; i < 3; i++) step(1, 1, 0, 1, 3, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) step(1, 0, 1, 1, 3, 0, 0, 0, 0);
        step(1, 1, 1, 1, 3, 0, 1, 1, 4'h2);
        step(1, 1, 1, 1, 3, 0, 1, 2, 4'h3);

        // Reset mid-scan with imode held high
        step(0, 1, 1, 1, 3, 0, 0, 0, 0);
        step(1, 1, 1, 1, 3, 1, 1, 3, 4'h4);
        step(1, 1, 1, 1, 3, 0, 1, 0, 4'h1);
        step(1, 1, 1, 1, 3, 0, 1, 0, 4'h1);

        // Falling imode: transition-cycle load still uses scan channel, then manual
        step(1, 1, 1, 0, 2, 0, 1, 1, 4'h2);
        step(1, 1, 1, 0, 2, 0, 1, 2, 4'h3);

        // Drain
        step(1, 0, 1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        tot_cnt++;
        if (q.size() != 0)
            $display("FAIL drain: %0d words still expected, want 0", q.size());
        else
            pass_cnt++;

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule

// File: doc/mux_n1_reg.md
Name: mux_n1_reg

Overview:
- Parametrised N-channel, WIDTH-bit registered multiplexer; generalises the 4:1 combinational selector.
- Two select modes: manual (select port) or auto-scan (round-robin, fixed dwell per channel).
- One-stage registered output with valid/ready handshake and channel tag.
- Feeds shared downstream consumers (display, serial or compare logic) from several sources.

Parameters:
WIDTH, 4, bits per channel
NCH, 4, number of input channels (>=2)
DWELL, 2, accepted samples per channel before auto-scan advances (>=1)
SELW, $clog2(NCH), select and tag width (localparam, derived)

Ports:
iclk  input  1  clock, rising edge
irst_n  input  1  synchronous active-low reset
idata  input  NCH*WIDTH  flattened inputs; channel k at [k*WIDTH +: WIDTH]
isel  input  SELW  manual channel select
imode  input  1  0 = manual, 1 = auto-scan
ivalid  input  1  upstream sample valid
iready  input  1  downstream ready
odata  output  WIDTH  registered selected data
och  output  SELW  channel tag of odata
ovalid  output  1  odata/och valid

Behaviour:
- Single clock iclk. Reset irst_n is synchronous and active-low, sampled on the rising edge of iclk.
- Reset values: odata=0, och=0, ovalid=0, FSM=MANUAL, scan_ch=0, dwell_cnt=0, mode_q=0.
- Reset overrides every other input in the same cycle.
- load = ivalid && (!ovalid || iready).
- On load: odata <= data[cur_sel], och <= cur_sel, ovalid <= 1.
- Latency: exactly one cycle from the input cycle to the output.
- When !ivalid && iready: ovalid <= 0, odata and och hold.
- When ovalid && !iready: odata, och and ovalid hold. No input is consumed and scan state is frozen.
- MANUAL state: cur_sel = isel, sampled in the load cycle.
- Out-of-range isel (>= NCH, only possible when NCH is not a power of 2): odata loads 0, och loads isel, ovalid=1.
- SCAN state: cur_sel = scan_ch.
  - dwell_cnt increments only on load.
  - When a load occurs with dwell_cnt == DWELL-1: dwell_cnt <= 0 and scan_ch advances, wrapping NCH-1 -> 0.
  - Stalls and !ivalid cycles never advance the scan, so no channel is skipped.
- FSM transitions, edge-detected with mode_q (the registered imode):
  - MANUAL -> SCAN on imode rising: scan_ch <= 0 and dwell_cnt <= 0. The first scan load uses channel 0.
  - SCAN -> MANUAL on imode falling: scan_ch and dwell_cnt cleared.
  - A load in a transition cycle uses the select of the state being left.
- A held output is never corrupted by mode changes; the pending word stays until accepted.
- Reset mid-scan: the next load after release uses manual mode or channel 0, as imode dictates. The transition is detected one cycle later.

Optional Feature:
- Macro MUX_PARITY_EN.
- Defined: extra output oparity (1 bit) = XOR-reduce of the loaded word. It is registered with odata, reset 0, and holds under stall.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
All scenarios use WIDTH=4, NCH=4, DWELL=2, idata ch0..ch3 = 4'h1, 4'h2, 4'h3, 4'h4.
1. Reset: irst_n=0 for 3 cycles with ivalid=1, iready=1 -> odata=0, och=0, ovalid=0 throughout, then first load one cycle after release.
2. Manual sweep: imode=0, ivalid=1, iready=1, isel 0,1,2,3 on successive cycles -> one cycle later odata 1,2,3,4 and och 0,1,2,3. With MUX_PARITY_EN, oparity 1,1,0,1.
3. Backpressure: load isel=1, then iready=0 for 3 cycles while isel=3 -> odata=2, och=1, ovalid=1 held. iready=1 -> next cycle odata=4, och=3.
4. Auto-scan: imode 0->1, ivalid=1, iready=1 for 10 loads -> och 0,0,1,1,2,2,3,3,0,0 and odata 1,1,2,2,3,3,4,4,1,1 (wrap checked).
5. Scan stall and bubble: during scan, iready=0 for 3 cycles after the first ch1 load, then ivalid=0 for 2 cycles -> sequence continues with the second ch1 load. ovalid drops during the bubble only once the held word is accepted.
6. Reset mid-scan while och=2: assert irst_n=0 for 1 cycle, keep imode=1 -> after release, first loads are manual (isel=3 -> odata=4). After edge detection, scan restarts at channel 0 (odata=1).
